mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the processor's instruction-cache and data-cache miss buses (`Icache_bus_out`/`Icache_bus_in`, `Dcache_bus_out`/`Dcache_bus_in`) onto one single-ported main-memory interface. It sits directly downstream of `processor`, between the two cache buses and external memory. It serialises transactions with D-priority and alternation fairness, latches request fields for the memory side, and aborts stuck transactions with a watchdog.

## Interface
- `TIMEOUT`, 255: cycles to wait for `mem_ack` before aborting; 0 disables the watchdog.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an aborted read.
- `Clk` in 1: single clock; all state on its rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `Icache_bus_out` in 66: I request; [65]=req, [64]=we, [63:32]=addr, [31:0]=wdata.
- `Icache_bus_in` out 33: I response; [32]=ack (one-cycle pulse), [31:0]=rdata.
- `Dcache_bus_out` in 66: D request, same layout as I.
- `Dcache_bus_in` out 33: D response, same layout as I.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: write enable for the latched transaction.
- `mem_addr` out 32: latched address.
- `mem_wdata` out 32: latched write data.
- `mem_ack` in 1: one-cycle pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: memory read data.
- `o_timeout` out 1: one-cycle pulse when the watchdog aborts a transaction.

## Operation
- States:
  - IDLE: no transaction.
  - GRANT_D / GRANT_I: memory transaction in flight for D or I.
  - RESP: one cycle; ack presented to the owner.
- IDLE arbitration:
  - D only pending: grant D.
  - I only pending: grant I.
  - Both pending: D wins, unless `last_grant`=D, then I wins.
  - `last_grant` updates on each grant.
- On grant:
  - Latch we/addr/wdata of the winner into `mem_*`; set `mem_req`=1.
  - Clear the watchdog counter.
- GRANT_x with `mem_ack`=1:
  - `mem_req`←0.
  - Owner rdata ← `mem_rdata` on reads, 0 on writes.
  - Owner ack←1; go to RESP.
- GRANT_x with no ack:
  - Counter increments.
  - When counter reaches TIMEOUT-1 (TIMEOUT≠0): `mem_req`←0; owner ack←1 with rdata=ERR_DATA on reads, 0 on writes; `o_timeout`←1; go to RESP.
- RESP:
  - Clear ack and `o_timeout`; go to IDLE.
  - No grant is issued in RESP, so a requester that drops req on the ack cycle is never double-served.
- Requester rules: hold req and fields stable until ack; drop or replace the request in the ack cycle.
- Non-owner response bus: ack=0 always; rdata holds its last value.
- `mem_ack` outside GRANT_x is ignored, including a stale ack after reset or timeout.
- Reset:
  - state=IDLE, `last_grant`=I (D wins first contention), counter=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Both response buses=0; `o_timeout`=0.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Request seen in cycle 0 (IDLE) → `mem_req` high in cycle 1.
- `mem_ack` in cycle n → requester ack in cycle n+1 → IDLE in cycle n+2.
- Minimum latency, request to ack: 2 cycles. Back-to-back throughput: one transaction per 3 cycles with a 1-cycle memory.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles; ack and `o_timeout` assert in the following cycle.
- `mem_ack` arriving in the same cycle the counter hits its limit: the genuine ack wins, with real data and no `o_timeout`.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous); no ack is ever delivered for the aborted transaction.

## Structure
- Shared package `mem_bus_pkg` (used by `processor` and the caches) holds:
  - Bus field positions: REQ=65, WE=64, ADDR_HI/LO=63/32, DATA_HI/LO=31/0, ACK=32.
  - Bus widths 66/33.
  - Arbiter state encoding.
- No sub-module is natural; the watchdog is an inline counter of width $clog2(TIMEOUT+1).

## Test plan
- Single D read at addr 0x100, memory acks in cycle 3 with 0x12345678 → `mem_req` in cycles 1–3, D ack + rdata 0x12345678 in cycle 4, I ack stays 0.
- D and I requests both raised in cycle 0 after reset → D granted first, then I; the second `mem_req` rises in the cycle after RESP.
- D write held continuously plus I read pending → order D, I, D, I; neither side starves; D write acks carry rdata=0.
- TIMEOUT=4, memory never acks on an I read → `mem_req` high 4 cycles, then I ack with 0xDEADBEEF and an `o_timeout` pulse; a later stray `mem_ack` is ignored.
- `mem_ack` coincides with the watchdog limit → normal data returned, `o_timeout` stays 0.
- `Rst` pulsed while in GRANT_D → all outputs 0 immediately, no D ack afterwards; next contention grants D first.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the processor cache-miss buses and the
// memory arbiter that serialises them onto main memory.
//
// Request bus (cache -> arbiter), BUS_OUT_W bits:
//   [REQ] req, [WE] write enable, [ADDR_HI:ADDR_LO] addr, [DATA_HI:DATA_LO] wdata
// Response bus (arbiter -> cache), BUS_IN_W bits:
//   [ACK] one-cycle ack, [DATA_HI:DATA_LO] rdata
package mem_bus_pkg;

  localparam int BUS_OUT_W = 66;
  localparam int BUS_IN_W  = 33;

  localparam int REQ     = 65;
  localparam int WE      = 64;
  localparam int ADDR_HI = 63;
  localparam int ADDR_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;
  localparam int ACK     = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_D = 2'd1,
    ARB_GRANT_I = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the instruction-cache and data-cache miss buses onto
// one single-ported main-memory interface. D has priority, but if D won the
// previous grant and both are pending, I is served (alternation fairness).
// A watchdog aborts a transaction that sees no mem_ack within TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT  - cycles mem_req stays high before abort; 0 disables the watchdog
//   ERR_DATA - read data returned on an aborted read
// Ports:
//   Clk, Rst           - clock, asynchronous active-high reset
//   Icache_bus_out     - I request {req, we, addr, wdata}
//   Icache_bus_in      - I response {ack, rdata}
//   Dcache_bus_out     - D request, same layout
//   Dcache_bus_in      - D response, same layout
//   mem_req/we/addr/wdata - registered memory request, held until mem_ack
//   mem_ack, mem_rdata - memory completion pulse and read data
//   o_timeout          - one-cycle pulse when the watchdog aborts
// All outputs come straight from flops.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [BUS_OUT_W-1:0] Icache_bus_out,
  output logic [BUS_IN_W-1:0]  Icache_bus_in,
  input  logic [BUS_OUT_W-1:0] Dcache_bus_out,
  output logic [BUS_IN_W-1:0]  Dcache_bus_in,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 o_timeout
);

  // A width of at least one keeps the counter legal when the watchdog is off.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic             last_d_q, last_d_d;   // 1: previous grant went to D
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mem_req_d, mem_we_d;
  logic [31:0]      mem_addr_d, mem_wdata_d;
  logic             i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [31:0]      i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic             tmo_d;
  logic [31:0]      resp_data;
  logic             finish;

  logic i_req, d_req;
  assign i_req = Icache_bus_out[REQ];
  assign d_req = Dcache_bus_out[REQ];

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    tmo_d       = 1'b0;
    resp_data   = 32'h0;
    finish      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (d_req && (!i_req || !last_d_q)) begin
          state_d     = ARB_GRANT_D;
          last_d_d    = 1'b1;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = Dcache_bus_out[WE];
          mem_addr_d  = Dcache_bus_out[ADDR_HI:ADDR_LO];
          mem_wdata_d = Dcache_bus_out[DATA_HI:DATA_LO];
        end else if (i_req) begin
          state_d     = ARB_GRANT_I;
          last_d_d    = 1'b0;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = Icache_bus_out[WE];
          mem_addr_d  = Icache_bus_out[ADDR_HI:ADDR_LO];
          mem_wdata_d = Icache_bus_out[DATA_HI:DATA_LO];
        end
      end

      ARB_GRANT_D, ARB_GRANT_I: begin
        // A genuine ack takes precedence over a watchdog expiry in the same cycle.
        if (mem_ack) begin
          finish    = 1'b1;
          resp_data = mem_we ? 32'h0 : mem_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIM)) begin
          finish    = 1'b1;
          tmo_d     = 1'b1;
          resp_data = mem_we ? 32'h0 : ERR_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        if (finish) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          if (state_q == ARB_GRANT_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = resp_data;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = resp_data;
          end
        end
      end

      // No grant here: a requester that drops req on its ack cycle must not
      // be picked up again from the still-stable request it held.
      ARB_RESP: state_d = ARB_IDLE;

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ARB_IDLE;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      o_timeout <= tmo_d;
    end
  end

  assign Icache_bus_in = {i_ack_q, i_rdata_q};
  assign Dcache_bus_in = {d_ack_q, d_rdata_q};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_bus_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [65:0] Icache_bus_out = '0;
  logic [65:0] Dcache_bus_out = '0;
  logic [32:0] Icache_bus_in, Dcache_bus_in;
  logic        mem_req, mem_we, mem_ack = 1'b0, o_timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .Clk(Clk), .Rst(Rst),
    .Icache_bus_out(Icache_bus_out), .Icache_bus_in(Icache_bus_in),
    .Dcache_bus_out(Dcache_bus_out), .Dcache_bus_in(Dcache_bus_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .o_timeout(o_timeout)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        i_req, i_we;
    logic [31:0] i_addr, i_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_dack;
    logic [31:0] e_drd;
    logic        e_iack;
    logic [31:0] e_ird;
    logic        e_tmo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic e_we,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic e_dack, input logic [31:0] e_drd,
                         input logic e_iack, input logic [31:0] e_ird, input logic e_tmo);
    chk({tag, ".mem_req"},   32'(mem_req),           32'(e_req));
    chk({tag, ".mem_we"},    32'(mem_we),            32'(e_we));
    chk({tag, ".mem_addr"},  mem_addr,               e_addr);
    chk({tag, ".mem_wdata"}, mem_wdata,              e_wdata);
    chk({tag, ".d_ack"},     32'(Dcache_bus_in[32]), 32'(e_dack));
    chk({tag, ".d_rdata"},   Dcache_bus_in[31:0],    e_drd);
    chk({tag, ".i_ack"},     32'(Icache_bus_in[32]), 32'(e_iack));
    chk({tag, ".i_rdata"},   Icache_bus_in[31:0],    e_ird);
    chk({tag, ".timeout"},   32'(o_timeout),         32'(e_tmo));
  endtask

  task automatic set_d(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    Dcache_bus_out = {req, we, addr, wd};
  endtask

  task automatic set_i(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    Icache_bus_out = {req, we, addr, wd};
  endtask

  task automatic set_mem(input logic ack, input logic [31:0] rd);
    mem_ack   = ack;
    mem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    // Single D read at 0x100, memory acks in the third mem_req cycle.
    tbl.push_back('{0, 1,0,32'h100,0, 0,0,0,0, 0,0,            1,0,32'h100,0, 0,0,            0,0, 0});
    tbl.push_back('{0, 1,0,32'h100,0, 0,0,0,0, 0,0,            1,0,32'h100,0, 0,0,            0,0, 0});
    tbl.push_back('{0, 1,0,32'h100,0, 0,0,0,0, 0,0,            1,0,32'h100,0, 0,0,            0,0, 0});
    tbl.push_back('{0, 1,0,32'h100,0, 0,0,0,0, 1,32'h12345678, 0,0,32'h100,0, 1,32'h12345678, 0,0, 0});
    tbl.push_back('{0, 0,0,0,0,       0,0,0,0, 0,0,            0,0,32'h100,0, 0,32'h12345678, 0,0, 0});
    tbl.push_back('{0, 0,0,0,0,       0,0,0,0, 0,0,            0,0,32'h100,0, 0,32'h12345678, 0,0, 0});
    // Simultaneous D and I after reset: D first, then I.
    tbl.push_back('{1, 0,0,0,0,       0,0,0,0,       0,0,            0,0,0,0,       0,0,            0,0,            0});
    tbl.push_back('{0, 1,0,32'h200,0, 1,0,32'h300,0, 0,0,            1,0,32'h200,0, 0,0,            0,0,            0});
    tbl.push_back('{0, 1,0,32'h200,0, 1,0,32'h300,0, 1,32'hAAAA0001, 0,0,32'h200,0, 1,32'hAAAA0001, 0,0,            0});
    tbl.push_back('{0, 0,0,0,0,       1,0,32'h300,0, 0,0,            0,0,32'h200,0, 0,32'hAAAA0001, 0,0,            0});
    tbl.push_back('{0, 0,0,0,0,       1,0,32'h300,0, 0,0,            1,0,32'h300,0, 0,32'hAAAA0001, 0,0,            0});
    tbl.push_back('{0, 0,0,0,0,       1,0,32'h300,0, 1,32'hBBBB0002, 0,0,32'h300,0, 0,32'hAAAA0001, 1,32'hBBBB0002, 0});
    tbl.push_back('{0, 0,0,0,0,       0,0,0,0,       0,0,            0,0,32'h300,0, 0,32'hAAAA0001, 0,32'hBBBB0002, 0});
    // D write held continuously against a pending I read: D, I, D, I.
    tbl.push_back('{1, 0,0,0,0,                  0,0,0,0,             0,0,            0,0,0,0,                  0,0, 0,0,            0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 0,0,            1,1,32'h400,32'h11112222, 0,0, 0,0,            0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 1,32'hFFFFFFFF, 0,1,32'h400,32'h11112222, 1,0, 0,0,            0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 0,0,            0,1,32'h400,32'h11112222, 0,0, 0,0,            0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 0,0,            1,0,32'h500,32'h99,       0,0, 0,0,            0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 1,32'hCCCC0003, 0,0,32'h500,32'h99,       0,0, 1,32'hCCCC0003, 0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 0,0,            0,0,32'h500,32'h99,       0,0, 0,32'hCCCC0003, 0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 0,0,            1,1,32'h400,32'h11112222, 0,0, 0,32'hCCCC0003, 0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 1,32'h00000012, 0,1,32'h400,32'h11112222, 1,0, 0,32'hCCCC0003, 0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 0,0,            0,1,32'h400,32'h11112222, 0,0, 0,32'hCCCC0003, 0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 0,0,            1,0,32'h500,32'h99,       0,0, 0,32'hCCCC0003, 0});
    tbl.push_back('{0, 1,1,32'h400,32'h11112222, 1,0,32'h500,32'h99, 1,32'hCCCC0004, 0,0,32'h500,32'h99,       0,0, 1,32'hCCCC0004, 0});
    tbl.push_back('{0, 0,0,0,0,                  0,0,0,0,             0,0,            0,0,32'h500,32'h99,       0,0, 0,32'hCCCC0004, 0});
    // Stray mem_ack while idle is ignored.
    tbl.push_back('{0, 0,0,0,0,                  0,0,0,0,             1,32'h77777777, 0,0,32'h500,32'h99,       0,0, 0,32'hCCCC0004, 0});

    // Reset state.
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Rst = 1'b0;

    foreach (tbl[k]) begin
      Rst = tbl[k].rst;
      set_d(tbl[k].d_req, tbl[k].d_we, tbl[k].d_addr, tbl[k].d_wdata);
      set_i(tbl[k].i_req, tbl[k].i_we, tbl[k].i_addr, tbl[k].i_wdata);
      set_mem(tbl[k].ack, tbl[k].rdata);
      tick();
      chk_all($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_we, tbl[k].e_addr, tbl[k].e_wdata,
              tbl[k].e_dack, tbl[k].e_drd, tbl[k].e_iack, tbl[k].e_ird, tbl[k].e_tmo);
    end
    Rst = 1'b0;
    set_d(0, 0, 0, 0); set_i(0, 0, 0, 0); set_mem(0, 0);

    // Watchdog expiry on an I read: mem_req high exactly 4 cycles.
    do_reset();
    set_i(1, 0, 32'h600, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_all($sformatf("tmo.wait%0d", c), 1, 0, 32'h600, 0, 0, 0, 0, 0, 0);
    end
    tick();
    chk_all("tmo.abort", 0, 0, 32'h600, 0, 0, 0, 1, 32'hDEADBEEF, 1);
    set_i(0, 0, 0, 0);
    set_mem(1, 32'h31313131);
    tick();
    chk_all("tmo.stray1", 0, 0, 32'h600, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    tick();
    chk_all("tmo.stray2", 0, 0, 32'h600, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    set_mem(0, 0);

    // mem_ack in the same cycle the watchdog reaches its limit.
    do_reset();
    set_d(1, 0, 32'h700, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_all($sformatf("race.wait%0d", c), 1, 0, 32'h700, 0, 0, 0, 0, 0, 0);
    end
    set_mem(1, 32'h5A5A5A5A);
    tick();
    chk_all("race.ack", 0, 0, 32'h700, 0, 1, 32'h5A5A5A5A, 0, 0, 0);
    set_d(0, 0, 0, 0);
    set_mem(0, 0);
    tick();
    chk_all("race.resp", 0, 0, 32'h700, 0, 0, 32'h5A5A5A5A, 0, 0, 0);

    // Asynchronous reset while D owns memory.
    do_reset();
    set_d(1, 1, 32'h800, 32'hABC);
    tick();
    chk_all("arst.grant", 1, 1, 32'h800, 32'hABC, 0, 0, 0, 0, 0);
    #2;
    Rst = 1'b1;
    #1;
    chk_all("arst.immediate", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_d(0, 0, 0, 0);
    set_mem(1, 32'h44);
    tick();
    Rst = 1'b0;
    tick();
    chk_all("arst.stale_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mem(0, 0);
    set_d(1, 0, 32'h900, 0);
    set_i(1, 0, 32'hA00, 0);
    tick();
    chk_all("arst.d_first", 1, 0, 32'h900, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
